// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg
//   Shared constants for the UART receive buffer:
//   - bit positions of the status flags in the CPU read word
//   - capture FSM state encodings
//   - default FIFO geometry
package uart_rx_fifo_pkg;

  // Status bits in the CPU read word
  localparam int UART_EMPTY_BIT = 15;
  localparam int UART_OVR_BIT   = 14;

  // Capture FSM encodings
  localparam logic [1:0] ARMED    = 2'd0;
  localparam logic [1:0] CLEARING = 2'd1;
  localparam logic [1:0] WAIT_INV = 2'd2;

  // Default FIFO geometry (DEPTH must be 2**AW)
  localparam int UART_RX_DEPTH = 16;
  localparam int UART_RX_AW    = 4;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Groups the receiver-side, CPU-side and debug signals of uart_rx_fifo.
//   rx_in     receiver word (bit 15 = 1: no valid byte, bits 7:0 = byte)
//   rx_clear  one-cycle pulse that resets the receiver after a capture
//   load      CPU write strobe, pops one entry
//   out       CPU read word {empty, overrun, 6'b0, head}
//   dbg_state capture FSM state
//   dbg_count FIFO occupancy
//
//   Handshake: there is no valid/ready pair. A byte is offered while
//   rx_in[15] == 0 and is taken exactly once; the taker acknowledges with a
//   single rx_clear pulse and re-arms only after the receiver shows
//   rx_in[15] == 1. A pop happens on every clock edge where load == 1 and
//   the FIFO is non-empty; load on an empty FIFO is ignored.
interface uart_rx_fifo_if #(
  parameter int AW = 4
);
  logic [15:0] rx_in;
  logic        rx_clear;
  logic        load;
  logic [15:0] out;
  logic [1:0]  dbg_state;
  logic [AW:0] dbg_count;

  // Driving side: receiver model plus CPU
  modport master (
    output rx_in,
    output load,
    input  rx_clear,
    input  out,
    input  dbg_state,
    input  dbg_count
  );

  // Buffer side
  modport slave (
    input  rx_in,
    input  load,
    output rx_clear,
    output out,
    output dbg_state,
    output dbg_count
  );
endinterface

// File: rtl/uart_rx_fifo_byte_fifo.sv
// byte_fifo
//   DEPTH x 8 register-array FIFO with registered occupancy count.
//   Ports:
//     clk, reset  clock, asynchronous active-high reset
//     push, din   write din at the tail (caller guarantees room or a same-edge pop)
//     pop         advance the head (caller guarantees non-empty)
//     dout        current head entry (combinational from mem[rd_ptr])
//     full, empty occupancy flags
//     count       occupancy 0..DEPTH
//   The storage array is not reset; only pointers and count are.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // When full, a push paired with a pop writes into the slot being vacated
  // (wr_ptr == rd_ptr); the old head is consumed on the same edge.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive buffer between the UART receiver and the CPU read register.
//   Captures each valid receiver byte once, queues it in byte_fifo, pulses
//   rx_clear to re-arm the receiver, and presents the queue head to the CPU.
//   Ports:
//     clk    system clock, all state on the rising edge
//     reset  asynchronous active-high reset
//     bus    uart_rx_fifo_if.slave: rx_in, rx_clear, load, out, dbg_state,
//            dbg_count
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = UART_RX_DEPTH,
  parameter int AW    = UART_RX_AW
) (
  input  logic             clk,
  input  logic             reset,
  uart_rx_fifo_if.slave    bus
);

  logic [1:0]  state;
  logic [1:0]  state_n;
  logic        capture;
  logic        rx_clear_q;
  logic        overrun;

  logic        push_ok;
  logic        pop_ok;
  logic        drop;
  logic [7:0]  head;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic [15:0] out_w;

  // Receiver bits 14:8 carry nothing the buffer needs.
  logic unused_rx_bits;
  assign unused_rx_bits = ^bus.rx_in[14:8];

  // Capture FSM: take a valid word once, spend one cycle pulsing rx_clear,
  // then wait until the receiver shows invalid before re-arming so a word
  // that is still held valid is never taken twice.
  always_comb begin
    state_n = state;
    capture = 1'b0;
    case (state)
      ARMED: begin
        if (!bus.rx_in[15]) begin
          capture = 1'b1;
          state_n = CLEARING;
        end
      end
      CLEARING: state_n = WAIT_INV;
      WAIT_INV: begin
        if (bus.rx_in[15]) begin
          state_n = ARMED;
        end
      end
      default: state_n = ARMED;
    endcase
  end

  // Pop is judged on the pre-edge count; a full FIFO still accepts a push
  // when a pop frees a slot on the same edge.
  assign pop_ok  = bus.load && !empty;
  assign push_ok = capture && (!full || pop_ok);
  assign drop    = capture && !push_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARMED;
      rx_clear_q <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      rx_clear_q <= capture;
      // Sticky drop flag; a drop on the same edge as a pop wins.
      if (drop) begin
        overrun <= 1'b1;
      end else if (pop_ok) begin
        overrun <= 1'b0;
      end
    end
  end

  byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .din   (bus.rx_in[7:0]),
    .pop   (pop_ok),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Head byte is masked while empty so uninitialised storage never shows.
  always_comb begin
    out_w                 = 16'h0000;
    out_w[UART_EMPTY_BIT] = empty;
    out_w[UART_OVR_BIT]   = overrun;
    out_w[7:0]            = empty ? 8'h00 : head;
  end

  assign bus.out       = out_w;
  assign bus.rx_clear  = rx_clear_q;
  assign bus.dbg_state = state;
  assign bus.dbg_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo (DEPTH = 16). Inputs are driven 1 ns
//   after the rising edge and outputs are checked at that same point, well
//   away from the next edge.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.AW(4)) bus_if ();

  uart_rx_fifo #(
    .DEPTH (16),
    .AW    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  // ---------------- scoreboard ----------------
  int          vec_cnt;
  int          err_cnt;
  logic [7:0]  exp_q[$];

  task automatic check_eq(input string tag, input logic [15:0] got,
                          input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte, then behave like a receiver that goes invalid after
  // the rx_clear pulse; returns with the FSM back in ARMED.
  task automatic push_byte(input logic [7:0] b);
    bus_if.rx_in = {8'h00, b};
    tick();
    bus_if.rx_in = 16'h8000;
    tick();
    tick();
  endtask

  // Compare the head with the next expected byte, then pop it.
  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_qempty"}, 16'h0001, 16'h0000);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, {bus_if.out[15], 7'h00, bus_if.out[7:0]}, {8'h00, e});
    end
    bus_if.load = 1'b1;
    tick();
    bus_if.load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    reset        = 1'b1;
    bus_if.rx_in = 16'h8000;
    bus_if.load  = 1'b0;
    #23;
    reset = 1'b0;
    tick();

    // Reset state and idle
    check_eq("rst_out",   bus_if.out, 16'h8000);
    check_eq("rst_clr",   16'(bus_if.rx_clear), 16'h0000);
    check_eq("rst_state", 16'(bus_if.dbg_state), 16'(ARMED));
    check_eq("rst_count", 16'(bus_if.dbg_count), 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("idle_clr", 16'(bus_if.rx_clear), 16'h0000);
    end
    check_eq("idle_out", bus_if.out, 16'h8000);

    // Held valid word is captured once, rx_clear pulses for one cycle
    bus_if.rx_in = 16'h0041;
    tick();
    check_eq("hold_clr0", 16'(bus_if.rx_clear), 16'h0001);
    check_eq("hold_out0", bus_if.out, 16'h0041);
    for (int i = 1; i < 5; i++) begin
      tick();
      check_eq("hold_clr", 16'(bus_if.rx_clear), 16'h0000);
    end
    check_eq("hold_state", 16'(bus_if.dbg_state), 16'(WAIT_INV));
    check_eq("hold_count", 16'(bus_if.dbg_count), 16'h0001);
    check_eq("hold_out", bus_if.out, 16'h0041);
    bus_if.rx_in = 16'h8000;
    tick();
    check_eq("rearm_state", 16'(bus_if.dbg_state), 16'(ARMED));
    bus_if.load = 1'b1;
    tick();
    bus_if.load = 1'b0;
    check_eq("pop41_out", bus_if.out, 16'h8000);

    // 17 bytes into a 16-deep FIFO: last one dropped, overrun set
    for (int i = 1; i <= 17; i++) begin
      push_byte(8'(i));
      if (i <= 16) exp_q.push_back(8'(i));
    end
    check_eq("ovr_out",   bus_if.out, 16'h4001);
    check_eq("ovr_count", 16'(bus_if.dbg_count), 16'd16);
    pop_check("ovr_pop1");
    check_eq("ovr_clear", 16'(bus_if.out[14]), 16'h0000);
    for (int i = 2; i <= 16; i++) begin
      pop_check("ovr_pop");
    end
    check_eq("ovr_drained", bus_if.out, 16'h8000);

    // Full FIFO with a same-edge pop accepts the push without overrun
    for (int i = 0; i < 16; i++) begin
      push_byte(8'h80 + 8'(i));
      exp_q.push_back(8'h80 + 8'(i));
    end
    bus_if.rx_in = 16'h0099;
    bus_if.load  = 1'b1;
    tick();
    bus_if.load  = 1'b0;
    bus_if.rx_in = 16'h8000;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h99);
    check_eq("fullpp_out",   bus_if.out, 16'h0081);
    check_eq("fullpp_count", 16'(bus_if.dbg_count), 16'd16);
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      pop_check("fullpp_pop");
    end
    check_eq("fullpp_drained", bus_if.out, 16'h8000);

    // Simultaneous push and pop with two entries queued
    push_byte(8'h10);
    push_byte(8'h20);
    bus_if.rx_in = 16'h0030;
    bus_if.load  = 1'b1;
    tick();
    bus_if.load  = 1'b0;
    bus_if.rx_in = 16'h8000;
    check_eq("pp_out",   bus_if.out, 16'h0020);
    check_eq("pp_count", 16'(bus_if.dbg_count), 16'd2);
    check_eq("pp_clr",   16'(bus_if.rx_clear), 16'h0001);
    tick();
    tick();
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h30);
    pop_check("pp_pop20");
    pop_check("pp_pop30");
    check_eq("pp_drained", bus_if.out, 16'h8000);

    // Load while empty is ignored
    bus_if.load = 1'b1;
    tick();
    bus_if.load = 1'b0;
    check_eq("epop_out",   bus_if.out, 16'h8000);
    check_eq("epop_count", 16'(bus_if.dbg_count), 16'h0000);
    push_byte(8'h55);
    check_eq("epop_push", bus_if.out, 16'h0055);
    bus_if.load = 1'b1;
    tick();
    bus_if.load = 1'b0;
    check_eq("epop_drain", bus_if.out, 16'h8000);

    // Async reset during CLEARING with three bytes queued
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    bus_if.rx_in = 16'h0004;
    tick();
    check_eq("arst_pre_clr", 16'(bus_if.rx_clear), 16'h0001);
    check_eq("arst_pre_out", bus_if.out, 16'h00A1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_clr",   16'(bus_if.rx_clear), 16'h0000);
    check_eq("arst_out",   bus_if.out, 16'h8000);
    check_eq("arst_state", 16'(bus_if.dbg_state), 16'(ARMED));
    bus_if.rx_in = 16'h8000;
    #1;
    reset = 1'b0;
    tick();
    check_eq("arst_after_out",   bus_if.out, 16'h8000);
    check_eq("arst_after_count", 16'(bus_if.dbg_count), 16'h0000);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
